retro_bram_fill_dma: RTL

- Copy engine directly upstream of the single-cycle BRAM store (cartridge cache, VRAM preload).
- On a start pulse it streams Length words from a slow source memory port (SRAM/flash, variable latency) into consecutive BRAM addresses.
- It drives the BRAM target's Access/Write/Mask/Address/DToTarget port and is the sole BRAM initiator while Busy.

---
 rtl/retro_dma_pkg.sv | 24 ++
 rtl/retro_bram_fill_dma.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/retro_dma_pkg.sv
// rtl/retro_dma_pkg.sv - shared types and helpers for the BRAM fill DMA
package retro_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_DATA,
    DRAIN,
    FINISH
  } dma_state_t;

  localparam int MaxMaskBytes = 32;

  // Byte-lane enable vector with the low 'bytes' lanes set.
  function automatic logic [MaxMaskBytes-1:0] all_ones_mask(input int bytes);
    logic [MaxMaskBytes-1:0] m;
    m = '0;
    for (int i = 0; i < MaxMaskBytes; i++) begin
      if (i < bytes) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/retro_bram_fill_dma.sv
// rtl/retro_bram_fill_dma.sv - streams words from a slow source into consecutive BRAM addresses
module retro_bram_fill_dma
  import retro_dma_pkg::*;
#(
  parameter int SrcAddressWidth  = 19,
  parameter int BramAddressWidth = 12,
  parameter int DataBusWidth     = 1
) (
  input  logic                          Clk_i,
  input  logic                          Reset_i,
  input  logic                          Start_i,
  input  logic                          Abort_i,
  input  logic [SrcAddressWidth-1:0]    SrcBase_i,
  input  logic [BramAddressWidth-1:0]   BramBase_i,
  input  logic [BramAddressWidth:0]     Length_i,
  output logic                          Busy_o,
  output logic                          Done_o,
  output logic                          Aborted_o,
  output logic                          SrcAccess_o,
  output logic                          SrcWrite_o,
  output logic [SrcAddressWidth-1:0]    SrcAddress_o,
  input  logic                          SrcReady_i,
  input  logic                          SrcDataReady_i,
  input  logic [8*DataBusWidth-1:0]     SrcDToInitiator_i,
  output logic                          BramAccess_o,
  output logic                          BramWrite_o,
  output logic [DataBusWidth-1:0]       BramMask_o,
  output logic [BramAddressWidth-1:0]   BramAddress_o,
  output logic [8*DataBusWidth-1:0]     BramDToTarget_o
);

  localparam int DataWidth = 8 * DataBusWidth;
  localparam logic [MaxMaskBytes-1:0] MaskFull = all_ones_mask(DataBusWidth);

  dma_state_t                  state_q, state_d;
  logic [SrcAddressWidth-1:0]  src_addr_q, src_addr_d;
  logic [BramAddressWidth-1:0] bram_addr_q, bram_addr_d;
  logic [BramAddressWidth:0]   count_q, count_d;
  logic [BramAddressWidth-1:0] wr_addr_q, wr_addr_d;
  logic [DataWidth-1:0]        wr_data_q, wr_data_d;
  logic                        wr_q, wr_d;
  logic                        aborted_q, aborted_d;

  // Register bank: state, running addresses/count and the one-cycle BRAM write slot.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q     <= IDLE;
      src_addr_q  <= '0;
      bram_addr_q <= '0;
      count_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_q        <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      bram_addr_q <= bram_addr_d;
      count_q     <= count_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_q        <= wr_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state logic; a captured word is written the cycle after it arrives while the
  // next source request is already being issued.
  always_comb begin
    state_d     = state_q;
    src_addr_d  = src_addr_q;
    bram_addr_d = bram_addr_q;
    count_d     = count_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_d        = 1'b0;
    aborted_d   = aborted_q;
    unique case (state_q)
      IDLE: begin
        if (Start_i) begin
          aborted_d = 1'b0;
          if (Length_i == '0) begin
            state_d = FINISH;
          end else begin
            src_addr_d  = SrcBase_i;
            bram_addr_d = BramBase_i;
            count_d     = Length_i;
            state_d     = REQUEST;
          end
        end
      end
      REQUEST: begin
        // A request the source takes in the same cycle as Abort is still honoured.
        if (SrcReady_i) begin
          state_d = WAIT_DATA;
        end else if (Abort_i) begin
          aborted_d = 1'b1;
          state_d   = FINISH;
        end
      end
      WAIT_DATA: begin
        if (SrcDataReady_i) begin
          wr_d        = 1'b1;
          wr_data_d   = SrcDToInitiator_i;
          wr_addr_d   = bram_addr_q;
          bram_addr_d = bram_addr_q + BramAddressWidth'(1);
          src_addr_d  = src_addr_q + SrcAddressWidth'(1);
          count_d     = count_q - (BramAddressWidth + 1)'(1);
          if (count_q == (BramAddressWidth + 1)'(1)) begin
            state_d = FINISH;
          end else if (Abort_i) begin
            aborted_d = 1'b1;
            state_d   = FINISH;
          end else begin
            state_d = REQUEST;
          end
        end else if (Abort_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (SrcDataReady_i) begin
          aborted_d = 1'b1;
          state_d   = FINISH;
        end
      end
      FINISH: begin
        // Hold off completion until the final BRAM write has been issued.
        if (!wr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Done_o          = (state_q == FINISH) && !wr_q;
  assign Busy_o          = (state_q != IDLE) && !Done_o;
  assign Aborted_o       = Done_o && aborted_q;
  assign SrcAccess_o     = (state_q == REQUEST);
  assign SrcWrite_o      = 1'b0;
  assign SrcAddress_o    = SrcAccess_o ? src_addr_q : '0;
  assign BramAccess_o    = wr_q;
  assign BramWrite_o     = wr_q;
  assign BramMask_o      = wr_q ? MaskFull[DataBusWidth-1:0] : '0;
  assign BramAddress_o   = wr_q ? wr_addr_q : '0;
  assign BramDToTarget_o = wr_q ? wr_data_q : '0;

endmodule
